// File: rtl/hex_seg_dimmer_pkg.sv
// Shared constants and types for the hex segment dimmer.
//   PWM_STEPS : number of PWM steps per brightness period (15 -> bright 15 = always lit)
//   PWM_W     : width of the PWM step counter
//   SEG_OFF   : active-low pattern with every segment dark
//   SEG_ALL   : active-low pattern with every segment and the dp lit
// Optional feature macro used by the slice: HEX_DIMMER_LAMP_TEST_EN.
package hex_dimmer_pkg;

    localparam int PWM_STEPS = 15;
    localparam int PWM_W     = $clog2(PWM_STEPS - 1) + 1;

    typedef logic [7:0] seg_digit_t;

    localparam seg_digit_t SEG_OFF = 8'hFF;
    localparam seg_digit_t SEG_ALL = 8'h00;

endpackage

// File: rtl/hex_seg_dimmer_if.sv
// Signal bundle between the PIO side and the seven-segment pins.
//   seg_in    : raw active-low segment word, [7:0]=digit0, [15:8]=digit1
//   bright    : brightness 0..15
//   blink_en  : whole-display 50 % blink enable
//   lamp_test : force all segments lit (only with HEX_DIMMER_LAMP_TEST_EN)
//   hex0/hex1 : registered active-low digit pins
//   changed   : one-cycle strobe when seg_in changed
// master = driver of the controls (PIO side), slave = the dimmer.
interface hex_seg_dimmer_if;
    import hex_dimmer_pkg::*;

    logic [15:0] seg_in;
    logic [3:0]  bright;
    logic        blink_en;
`ifdef HEX_DIMMER_LAMP_TEST_EN
    logic        lamp_test;
`endif
    seg_digit_t  hex0;
    seg_digit_t  hex1;
    logic        changed;

`ifdef HEX_DIMMER_LAMP_TEST_EN
    modport master (output seg_in, bright, blink_en, lamp_test,
                    input  hex0, hex1, changed);
    modport slave  (input  seg_in, bright, blink_en, lamp_test,
                    output hex0, hex1, changed);
`else
    modport master (output seg_in, bright, blink_en,
                    input  hex0, hex1, changed);
    modport slave  (input  seg_in, bright, blink_en,
                    output hex0, hex1, changed);
`endif

endinterface

// File: rtl/hex_seg_dimmer_tick.sv
// Timebase for the dimmer: prescaler, PWM step counter and blink phase.
//   clk, reset_n     : clock, asynchronous active-low reset
//   blink_en_i       : blink enable; low holds the blink phase at "on"
//   step_o           : one-cycle pulse every PRESCALE clocks
//   period_start_o   : step on the last PWM count (start of next PWM period)
//   pwm_cnt_o        : current PWM step 0..PWM_STEPS-1
//   phase_o          : blink phase, 1 = display visible
module hex_dimmer_tick
    import hex_dimmer_pkg::*;
#(
    parameter int PRESCALE   = 50,
    parameter int BLINK_HALF = 833333
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             blink_en_i,
    output logic             step_o,
    output logic             period_start_o,
    output logic [PWM_W-1:0] pwm_cnt_o,
    output logic             phase_o
);

    localparam int PRE_W   = $clog2(PRESCALE - 1) + 1;
    localparam int BLINK_W = $clog2(BLINK_HALF - 1) + 1;

    logic [PRE_W-1:0]   pre_cnt_q;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               phase_q;

    logic step;
    logic period_start;
    logic blink_last;

    assign step         = (pre_cnt_q == PRE_W'(PRESCALE - 1));
    assign period_start = step && (pwm_cnt_q == PWM_W'(PWM_STEPS - 1));
    assign blink_last   = (blink_cnt_q == BLINK_W'(BLINK_HALF - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            pre_cnt_q <= step ? '0 : pre_cnt_q + PRE_W'(1);

            if (step) begin
                pwm_cnt_q <= period_start ? '0 : pwm_cnt_q + PWM_W'(1);
            end

            // Disabled blink parks in the visible phase so re-enabling
            // always begins with a full on half-phase.
            if (!blink_en_i) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b1;
            end else if (period_start) begin
                if (blink_last) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                end
            end
        end
    end

    assign step_o         = step;
    assign period_start_o = period_start;
    assign pwm_cnt_o      = pwm_cnt_q;
    assign phase_o        = phase_q;

endmodule

// File: rtl/hex_seg_dimmer.sv
// Seven-segment output stage: PWM dimming, optional blink and change strobe
// between the HEX PIO word and the HEX1/HEX0 pins.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : seg_in, bright, blink_en, [lamp_test] in; hex0, hex1, changed out
// Build option HEX_DIMMER_LAMP_TEST_EN adds lamp_test, which forces all
// segments lit on the next cycle regardless of PWM and blink.
module hex_seg_dimmer
    import hex_dimmer_pkg::*;
#(
    parameter int PRESCALE   = 50,
    parameter int BLINK_HALF = 833333
) (
    input  logic              clk,
    input  logic              reset_n,
    hex_seg_dimmer_if.slave   bus
);

    logic             tick_step;
    logic             tick_period_start;
    logic [PWM_W-1:0] tick_pwm_cnt;
    logic             tick_phase;

    hex_dimmer_tick #(
        .PRESCALE   (PRESCALE),
        .BLINK_HALF (BLINK_HALF)
    ) u_tick (
        .clk            (clk),
        .reset_n        (reset_n),
        .blink_en_i     (bus.blink_en),
        .step_o         (tick_step),
        .period_start_o (tick_period_start),
        .pwm_cnt_o      (tick_pwm_cnt),
        .phase_o        (tick_phase)
    );

    logic [15:0] seg_q;
    logic [3:0]  bright_q;
    logic        changed_q;
    seg_digit_t  hex0_q, hex0_d;
    seg_digit_t  hex1_q, hex1_d;
    logic        lit;
    logic        on;

    // bright_q starts at 0, so the display is dark until the first period start.
    assign lit = (tick_pwm_cnt < {1'b0, bright_q});
    assign on  = lit && (!bus.blink_en || tick_phase);

    always_comb begin
        hex0_d = SEG_OFF;
        hex1_d = SEG_OFF;
        if (on) begin
            hex0_d = seg_q[7:0];
            hex1_d = seg_q[15:8];
        end
`ifdef HEX_DIMMER_LAMP_TEST_EN
        if (bus.lamp_test) begin
            hex0_d = SEG_ALL;
            hex1_d = SEG_ALL;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q     <= 16'hFFFF;
            bright_q  <= '0;
            changed_q <= 1'b0;
            hex0_q    <= SEG_OFF;
            hex1_q    <= SEG_OFF;
        end else begin
            seg_q     <= bus.seg_in;
            changed_q <= (bus.seg_in != seg_q);
            // period_start is a qualified step; brightness only moves on
            // period boundaries so a period never shows a mixed duty.
            if (tick_step && tick_period_start) begin
                bright_q <= bus.bright;
            end
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
        end
    end

    assign bus.hex0    = hex0_q;
    assign bus.hex1    = hex1_q;
    assign bus.changed = changed_q;

endmodule
